// File: rtl/pixel_stream_pkg.sv
// Shared helpers for the pixel-stream blocks.
// Provides a ceiling-log2 for counter sizing, derived frame-geometry helpers
// and the FSM state encoding used by the stream transmitters.
package pixel_stream_pkg;

    // Smallest width w >= 1 with 2**w >= n, i.e. enough bits to hold 0..n-1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w++;
        end
        return w;
    endfunction

    // Cycles per line: active pixels stretched by the clken divider, then blanking.
    function automatic int unsigned line_len(input int unsigned h_active,
                                             input int unsigned clken_div,
                                             input int unsigned h_blank);
        return h_active * clken_div + h_blank;
    endfunction

    // Lines per frame: vsync lines, back porch, then active lines.
    function automatic int unsigned frame_lines(input int unsigned vsync_lines,
                                                input int unsigned v_blank,
                                                input int unsigned v_active);
        return vsync_lines + v_blank + v_active;
    endfunction

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

endpackage

// File: rtl/vid_timing_cnt.sv
// Horizontal / vertical / pixel-divider counters plus raster decode.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   run_i          counters advance while high, held at zero while low
//   vsync_o        current line is a vsync line
//   href_o         current cycle lies in the active region of an active line
//   slot_o         first cycle of a pixel group inside href
//   last_slot_o    slot of the final active pixel of the frame
//   frame_end_o    last cycle of the frame (counters wrap on the next edge)
module vid_timing_cnt
    import pixel_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_BLANK     = 160,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_BLANK     = 45,
    parameter int unsigned VSYNC_LINES = 2,
    parameter int unsigned CLKEN_DIV   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic vsync_o,
    output logic href_o,
    output logic slot_o,
    output logic last_slot_o,
    output logic frame_end_o
);

    localparam int unsigned LineLen   = line_len(H_ACTIVE, CLKEN_DIV, H_BLANK);
    localparam int unsigned FrameLns  = frame_lines(VSYNC_LINES, V_BLANK, V_ACTIVE);
    localparam int unsigned HrefEnd   = H_ACTIVE * CLKEN_DIV;
    localparam int unsigned ActStart  = VSYNC_LINES + V_BLANK;
    localparam int unsigned LastSlotH = (H_ACTIVE - 1) * CLKEN_DIV;
    localparam int unsigned HW        = clog2(LineLen);
    localparam int unsigned VW        = clog2(FrameLns);
    localparam int unsigned DW        = clog2(CLKEN_DIV);

    localparam logic [HW-1:0] HLast = HW'(LineLen - 1);
    localparam logic [VW-1:0] VLast = VW'(FrameLns - 1);
    localparam logic [DW-1:0] DLast = DW'(CLKEN_DIV - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [DW-1:0] div_q, div_d;
    logic          h_wrap;

    assign h_wrap = (h_q == HLast);

    always_comb begin
        h_d   = '0;
        v_d   = '0;
        div_d = '0;
        if (run_i) begin
            h_d   = h_wrap ? '0 : h_q + 1'b1;
            v_d   = h_wrap ? ((v_q == VLast) ? '0 : v_q + 1'b1) : v_q;
            // Divider restarts every line so each href begins on a slot.
            div_d = (h_wrap || div_q == DLast) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q   <= '0;
            v_q   <= '0;
            div_q <= '0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            div_q <= div_d;
        end
    end

    always_comb begin
        vsync_o     = run_i && (32'(v_q) < VSYNC_LINES);
        href_o      = run_i && (32'(v_q) >= ActStart) && (32'(h_q) < HrefEnd);
        slot_o      = href_o && (div_q == '0);
        last_slot_o = slot_o && (v_q == VLast) && (32'(h_q) == LastSlotH);
        frame_end_o = run_i && h_wrap && (v_q == VLast);
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Pixel-stream transmitter: pulls Y pixels from an upstream valid/ready source
// and replays them with fixed vsync/href/clken frame timing.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   enable             run request, only acted on at frame boundaries
//   src_valid/data     upstream pixel and its valid
//   src_ready          this cycle is a pixel slot (from registered counters)
//   post_frame_*       registered frame sync / line active / pixel strobe
//   post_img_y         Y pixel, valid when post_frame_clken is high
//   frame_done         one-cycle pulse after the last output clken of a frame
//   underflow          sticky, set when a slot found no valid pixel
module pixel_stream_tx
    import pixel_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_BLANK     = 160,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_BLANK     = 45,
    parameter int unsigned VSYNC_LINES = 2,
    parameter int unsigned CLKEN_DIV   = 1,
    parameter logic [7:0]  FILL_Y      = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       src_valid,
    input  logic [7:0] src_data,
    output logic       src_ready,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_y,
    output logic       frame_done,
    output logic       underflow
);

    logic [0:0] state_q, state_d;
    logic       run;
    logic       vsync_i, href_i, slot, last_slot, frame_end;
    logic       vsync_q, vsync_d;
    logic       href_q, href_d;
    logic       clken_q, clken_d;
    logic [7:0] y_q, y_d;
    logic       last_clken_q, last_clken_d;
    logic       done_q, done_d;
    logic       uflow_q, uflow_d;

    assign run = (state_q == StRun);

    vid_timing_cnt #(
        .H_ACTIVE   (H_ACTIVE),
        .H_BLANK    (H_BLANK),
        .V_ACTIVE   (V_ACTIVE),
        .V_BLANK    (V_BLANK),
        .VSYNC_LINES(VSYNC_LINES),
        .CLKEN_DIV  (CLKEN_DIV)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .run_i      (run),
        .vsync_o    (vsync_i),
        .href_o     (href_i),
        .slot_o     (slot),
        .last_slot_o(last_slot),
        .frame_end_o(frame_end)
    );

    assign src_ready = slot;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (frame_end && !enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vsync_d      = vsync_i;
        href_d       = href_i;
        clken_d      = slot;
        // Timing never stalls: a missing pixel is replaced, not waited for.
        y_d          = slot ? (src_valid ? src_data : FILL_Y) : y_q;
        uflow_d      = uflow_q || (slot && !src_valid);
        // Two stages: output clken lags the slot by one, frame_done by one more.
        last_clken_d = last_slot;
        done_d       = last_clken_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            clken_q      <= 1'b0;
            y_q          <= 8'd0;
            last_clken_q <= 1'b0;
            done_q       <= 1'b0;
            uflow_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            clken_q      <= clken_d;
            y_q          <= y_d;
            last_clken_q <= last_clken_d;
            done_q       <= done_d;
            uflow_q      <= uflow_d;
        end
    end

    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = href_q;
    assign post_frame_clken = clken_q;
    assign post_img_y       = y_q;
    assign frame_done       = done_q;
    assign underflow        = uflow_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: two instances (CLKEN_DIV 1 and 2) on a small
// 4x2 frame. A bench-side upstream source pushes each expected pixel into a
// scoreboard when it offers a slot; pixels are popped on each output clken.
module tb_pixel_stream_tx;

    localparam int HA = 4;
    localparam int HB = 3;
    localparam int VA = 2;
    localparam int VB = 1;
    localparam int VS = 1;
    localparam logic [7:0] FILL = 8'd0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       enable    [2];
    logic       src_valid [2];
    logic [7:0] src_data  [2];
    logic       src_ready [2];
    logic       vs        [2];
    logic       hr        [2];
    logic       ce        [2];
    logic [7:0] y         [2];
    logic       fd        [2];
    logic       uf        [2];

    pixel_stream_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .VSYNC_LINES(VS), .CLKEN_DIV(1), .FILL_Y(FILL)
    ) u_dut_div1 (
        .clk(clk), .rst(rst), .enable(enable[0]), .src_valid(src_valid[0]),
        .src_data(src_data[0]), .src_ready(src_ready[0]), .post_frame_vsync(vs[0]),
        .post_frame_href(hr[0]), .post_frame_clken(ce[0]), .post_img_y(y[0]),
        .frame_done(fd[0]), .underflow(uf[0])
    );

    pixel_stream_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .VSYNC_LINES(VS), .CLKEN_DIV(2), .FILL_Y(FILL)
    ) u_dut_div2 (
        .clk(clk), .rst(rst), .enable(enable[1]), .src_valid(src_valid[1]),
        .src_data(src_data[1]), .src_ready(src_ready[1]), .post_frame_vsync(vs[1]),
        .post_frame_href(hr[1]), .post_frame_clken(ce[1]), .post_img_y(y[1]),
        .frame_done(fd[1]), .underflow(uf[1])
    );

    int         tests;
    int         fails;
    int         cycle;
    int         drop_slot;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] next_pix  [2];
    int         slot_cnt  [2];
    int         n_vs      [2];
    int         n_hr      [2];
    int         n_ce      [2];
    int         n_rdy     [2];
    int         n_fd      [2];
    int         n_bad_ce  [2];
    int         href_idx  [2];
    int         vs_rises  [2];
    int         vs_first  [2];
    int         vs_last   [2];
    int         fd_first  [2];
    int         fd_last   [2];
    int         first_kind[2];
    logic       prev_vs   [2];

    // One clock of observation and upstream drive for instance d.
    task automatic step(input int d);
        logic [7:0] exp;
        int         qsz;
        @(negedge clk);
        cycle++;
        if (ce[d] === 1'b1) begin
            tests++;
            qsz = (d == 0) ? exp_q0.size() : exp_q1.size();
            if (qsz == 0) begin
                fails++;
                $display("FAIL pixel d%0d cyc %0d: clken with nothing expected, y=%0d",
                         d, cycle, y[d]);
            end else begin
                exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (y[d] !== exp) begin
                    fails++;
                    $display("FAIL pixel d%0d cyc %0d: y=%0d expected %0d", d, cycle, y[d], exp);
                end
            end
        end
        if (first_kind[d] == 0) begin
            if (vs[d] === 1'b1) first_kind[d] = 1;
            else if (hr[d] === 1'b1 || ce[d] === 1'b1 || fd[d] === 1'b1) first_kind[d] = 2;
        end
        if (vs[d] === 1'b1) begin
            n_vs[d]++;
            if (prev_vs[d] !== 1'b1) begin
                if (vs_rises[d] == 0) vs_first[d] = cycle;
                vs_last[d] = cycle;
                vs_rises[d]++;
            end
        end
        prev_vs[d] = vs[d];
        if (hr[d] === 1'b1) begin
            n_hr[d]++;
            if (ce[d] !== ((href_idx[d] % (d + 1)) == 0)) n_bad_ce[d]++;
            href_idx[d]++;
        end else begin
            if (ce[d] === 1'b1) n_bad_ce[d]++;
            href_idx[d] = 0;
        end
        if (ce[d] === 1'b1) n_ce[d]++;
        if (fd[d] === 1'b1) begin
            if (n_fd[d] == 0) fd_first[d] = cycle;
            fd_last[d] = cycle;
            n_fd[d]++;
        end
        src_data[d] = next_pix[d];
        if (src_ready[d] === 1'b1) begin
            n_rdy[d]++;
            slot_cnt[d]++;
            src_valid[d] = (slot_cnt[d] != drop_slot);
            exp = src_valid[d] ? next_pix[d] : FILL;
            if (d == 0) exp_q0.push_back(exp);
            else exp_q1.push_back(exp);
            if (src_valid[d]) next_pix[d]++;
        end else begin
            src_valid[d] = 1'b1;
        end
    endtask

    task automatic clear(input int d);
        if (d == 0) exp_q0.delete();
        else exp_q1.delete();
        next_pix[d]   = 8'd1;
        slot_cnt[d]   = 0;
        n_vs[d]       = 0;
        n_hr[d]       = 0;
        n_ce[d]       = 0;
        n_rdy[d]      = 0;
        n_fd[d]       = 0;
        n_bad_ce[d]   = 0;
        href_idx[d]   = 0;
        vs_rises[d]   = 0;
        vs_first[d]   = 0;
        vs_last[d]    = 0;
        fd_first[d]   = 0;
        fd_last[d]    = 0;
        first_kind[d] = 0;
        prev_vs[d]    = vs[d];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({vs[d], hr[d], ce[d], fd[d], uf[d], src_ready[d]} !== 6'b0) begin
                fails++;
                $display("FAIL reset_flags d%0d: vs/hr/ce/fd/uf/rdy=%b expected 000000", d,
                         {vs[d], hr[d], ce[d], fd[d], uf[d], src_ready[d]});
            end
            tests++;
            if (y[d] !== 8'd0) begin
                fails++;
                $display("FAIL reset_y d%0d: y=%0d expected 0", d, y[d]);
            end
        end
        rst = 1'b0;
        step(0);
    endtask

    task automatic test_single_frame(input int d);
        int div;
        div = d + 1;
        clear(d);
        enable[d] = 1'b1;
        step(d);
        enable[d] = 1'b0;
        repeat (60) step(d);
        tests++;
        if (n_vs[d] != VS * (HA * div + HB)) begin
            fails++;
            $display("FAIL frame_vsync d%0d: %0d cycles, expected %0d", d, n_vs[d],
                     VS * (HA * div + HB));
        end
        tests++;
        if (n_hr[d] != VA * HA * div) begin
            fails++;
            $display("FAIL frame_href d%0d: %0d cycles, expected %0d", d, n_hr[d], VA * HA * div);
        end
        tests++;
        if (n_ce[d] != 8 || n_rdy[d] != 8) begin
            fails++;
            $display("FAIL frame_count d%0d: clken=%0d ready=%0d, expected 8/8", d, n_ce[d],
                     n_rdy[d]);
        end
        tests++;
        if (n_bad_ce[d] != 0) begin
            fails++;
            $display("FAIL clken_phase d%0d: %0d misplaced clken cycles, expected 0", d,
                     n_bad_ce[d]);
        end
        tests++;
        if (n_fd[d] != 1 || uf[d] !== 1'b0) begin
            fails++;
            $display("FAIL frame_done d%0d: pulses=%0d underflow=%b, expected 1/0", d, n_fd[d],
                     uf[d]);
        end
        tests++;
        if (src_ready[d] !== 1'b0 || vs[d] !== 1'b0 || next_pix[d] != 8'd9) begin
            fails++;
            $display("FAIL frame_idle d%0d: ready=%b vs=%b next=%0d, expected 0/0/9", d,
                     src_ready[d], vs[d], next_pix[d]);
        end
    endtask

    task automatic test_underflow();
        clear(0);
        drop_slot = 3;
        enable[0] = 1'b1;
        step(0);
        enable[0] = 1'b0;
        repeat (40) step(0);
        drop_slot = -1;
        tests++;
        if (n_ce[0] != 8 || exp_q0.size() != 0 || next_pix[0] != 8'd8) begin
            fails++;
            $display("FAIL uflow_count: clken=%0d pending=%0d next=%0d, expected 8/0/8", n_ce[0],
                     exp_q0.size(), next_pix[0]);
        end
        repeat (10) step(0);
        tests++;
        if (uf[0] !== 1'b1) begin
            fails++;
            $display("FAIL uflow_sticky: underflow=%b expected 1", uf[0]);
        end
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        tests++;
        if (uf[0] !== 1'b0) begin
            fails++;
            $display("FAIL uflow_clear: underflow=%b expected 0", uf[0]);
        end
        step(0);
    endtask

    task automatic test_enable_mid();
        int c0;
        clear(0);
        enable[0] = 1'b1;
        repeat (10) step(0);
        enable[0] = 1'b0;
        repeat (40) step(0);
        tests++;
        if (n_ce[0] != 8 || n_vs[0] != 7 || n_fd[0] != 1 || n_rdy[0] != 8) begin
            fails++;
            $display("FAIL enable_mid: clken=%0d vs=%0d done=%0d rdy=%0d, expected 8/7/1/8",
                     n_ce[0], n_vs[0], n_fd[0], n_rdy[0]);
        end
        c0 = cycle;
        enable[0] = 1'b1;
        step(0);
        enable[0] = 1'b0;
        repeat (40) step(0);
        tests++;
        if (vs_rises[0] != 2 || vs_last[0] - c0 != 2) begin
            fails++;
            $display("FAIL enable_restart: rises=%0d vsync at +%0d, expected 2 rises at +2",
                     vs_rises[0], vs_last[0] - c0);
        end
        tests++;
        if (n_ce[0] != 16) begin
            fails++;
            $display("FAIL enable_restart_px: clken=%0d expected 16", n_ce[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        clear(0);
        enable[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step(0);
            if (hr[0] === 1'b1) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL rst_mid_wait: href never seen, got %b expected 1", hr[0]);
        end
        rst = 1'b1;
        step(0);
        tests++;
        if ({vs[0], hr[0], ce[0], fd[0], src_ready[0]} !== 5'b0 || y[0] !== 8'd0) begin
            fails++;
            $display("FAIL rst_mid_out: vs/hr/ce/fd/rdy=%b y=%0d, expected all 0",
                     {vs[0], hr[0], ce[0], fd[0], src_ready[0]}, y[0]);
        end
        rst = 1'b0;
        clear(0);
        step(0);
        enable[0] = 1'b0;
        repeat (40) step(0);
        tests++;
        if (first_kind[0] != 1 || n_vs[0] != 7) begin
            fails++;
            $display("FAIL rst_mid_restart: first=%0d vs=%0d, expected vsync first (1) / 7",
                     first_kind[0], n_vs[0]);
        end
        tests++;
        if (n_ce[0] != 8 || n_fd[0] != 1) begin
            fails++;
            $display("FAIL rst_mid_frame: clken=%0d done=%0d, expected 8/1", n_ce[0], n_fd[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear(0);
        enable[0] = 1'b1;
        repeat (40) step(0);
        enable[0] = 1'b0;
        repeat (40) step(0);
        tests++;
        if (vs_rises[0] != 2 || vs_last[0] - vs_first[0] != 28 || n_vs[0] != 14) begin
            fails++;
            $display("FAIL b2b_vsync: rises=%0d gap=%0d vs=%0d, expected 2/28/14", vs_rises[0],
                     vs_last[0] - vs_first[0], n_vs[0]);
        end
        tests++;
        if (n_fd[0] != 2 || fd_last[0] - fd_first[0] != 28) begin
            fails++;
            $display("FAIL b2b_done: pulses=%0d gap=%0d, expected 2/28", n_fd[0],
                     fd_last[0] - fd_first[0]);
        end
        tests++;
        if (n_ce[0] != 16 || exp_q0.size() != 0) begin
            fails++;
            $display("FAIL b2b_pixels: clken=%0d pending=%0d, expected 16/0", n_ce[0],
                     exp_q0.size());
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        cycle     = 0;
        drop_slot = -1;
        rst       = 1'b1;
        for (int d = 0; d < 2; d++) begin
            enable[d]    = 1'b0;
            src_valid[d] = 1'b1;
            src_data[d]  = 8'd0;
            clear(d);
            prev_vs[d]   = 1'b0;
        end
        test_reset();
        test_single_frame(0);
        test_single_frame(1);
        test_underflow();
        test_enable_mid();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
- Transmit end of the per-frame pixel-stream interface (vsync/href/clken/8-bit Y) consumed by the edge-detection and matrix blocks.
- Pulls Y pixels from an upstream buffer via a valid/ready handshake.
- Emits them with fixed, parameterised frame timing, so that stored or test images can be replayed into the processing chain in place of the CMOS source.

Parameters:
H_ACTIVE, 640, active pixels per line
H_BLANK, 160, blank cycles after each line's active region
V_ACTIVE, 480, active lines per frame
V_BLANK, 45, back-porch lines after vsync lines
VSYNC_LINES, 2, lines with vsync high at frame start
CLKEN_DIV, 1, active cycles per pixel (1..8); clken high on first cycle of each group
FILL_Y, 0, pixel value emitted on underflow

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  run request; sampled at frame boundaries
src_valid  in  1  upstream pixel valid
src_data  in  8  upstream Y pixel
src_ready  out  1  pixel slot this cycle (combinational from registered counters)
post_frame_vsync  out  1  frame sync
post_frame_href  out  1  line active
post_frame_clken  out  1  pixel strobe
post_img_y  out  8  Y pixel, valid when clken=1
frame_done  out  1  one-cycle pulse after last active pixel of a frame
underflow  out  1  sticky: a slot found src_valid=0

Behaviour:
- Reset:
  - Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
  - All outputs 0 on the cycle after `rst` is sampled high. State IDLE, counters 0.
  - `underflow` is cleared only by `rst`.
- States: IDLE, RUN.
  - IDLE → RUN when `enable`=1; the first RUN cycle is h=0, v=0.
  - RUN → IDLE at the end of the last cycle of a frame when `enable`=0.
  - Otherwise RUN continues with the next frame at h=0, v=0, with no gap cycle.
- Counters:
  - Line length L = H_ACTIVE*CLKEN_DIV + H_BLANK.
  - h counts 0..L-1, wraps and increments v.
  - v counts 0..VSYNC_LINES+V_BLANK+V_ACTIVE-1, wraps to 0.
  - Widths come from clog2 of the maxima.
- Internal timing (RUN only):
  - vsync_i = v < VSYNC_LINES.
  - active line = v >= VSYNC_LINES+V_BLANK.
  - href_i = active line and h < H_ACTIVE*CLKEN_DIV.
  - slot = href_i and (h mod CLKEN_DIV)=0, using a separate div counter rather than a modulo.
- src_ready = slot. In IDLE, src_ready = 0.
- Outputs are registered with 1-cycle latency from internal timing:
  - post_frame_vsync <= vsync_i.
  - post_frame_href <= href_i.
  - post_frame_clken <= slot.
- Handshake:
  - Transfer occurs when src_ready & src_valid; post_img_y <= src_data.
  - If slot & !src_valid: post_img_y <= FILL_Y, clken still asserted (timing never stalls), underflow <= 1.
  - post_img_y holds its value when clken=0.
- frame_done: registered pulse coincident with the clken of the last active pixel + 1 cycle (i.e. the cycle after the last output clken of a frame).
- `enable` changes mid-frame are ignored until the frame boundary.
- `rst` mid-frame aborts immediately; the next frame after release starts from v=0.
- src_data is never consumed outside a slot; upstream may hold src_valid high across blanking.

Decomposition:
- Shared package: a clog2 function and derived constants (line length, frame line count, counter widths) used by this block and future stream blocks.
- One sub-module: vid_timing_cnt (h/v/div counters plus vsync_i/href_i/slot decode).
- The top holds the FSM, handshake, output registers and flags.

Test Plan:
1. Single frame, src_valid=1, data 1..8. Params H_ACTIVE=4, H_BLANK=3, V_ACTIVE=2, V_BLANK=1, VSYNC_LINES=1, CLKEN_DIV=1; enable pulsed high for one frame.
   Required response:
   - vsync high 7 cycles.
   - href high 4 cycles on each of 2 lines.
   - 8 clken with post_img_y 1..8.
   - Exactly 8 src_ready.
   - frame_done once; underflow=0.
2. Same as scenario 1 but CLKEN_DIV=2 → href high 8 cycles per line; clken on alternate cycles starting with the first href cycle; 8 pixels total.
3. src_valid=0 during the 3rd slot only → that clken carries post_img_y=0 (FILL_Y); the next data continues in sequence; underflow rises and stays 1 until rst.
4. enable deasserted mid-frame → frame completes with all 8 pixels, then outputs and src_ready stay 0. enable reasserted → new frame starts with vsync 1 cycle after IDLE exit.
5. rst asserted during an active line for 1 cycle with enable=1 → all outputs 0 the next cycle; after release a full frame starts at v=0 (vsync first).
6. enable held for 2 frames → frame-2 vsync rises on the cycle immediately after frame 1's last blank cycle (frame period 28 cycles); frame_done pulses 28 cycles apart.
